// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider serving the execute stage's DIV/DIVU requests.
// Returns {remainder, quotient} with ready_o, held until the requester drops start_i.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH:0]   work_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               negQuot_q;
  logic               negRem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Operand magnitudes, trial subtraction and sign correction of the final result
  always_comb begin
    absA    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    absB    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    diff    = {1'b0, work_q[2*WIDTH:WIDTH]} - {2'b00, dvs_q};
    quotFix = negQuot_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
    remFix  = negRem_q ? -work_q[2*WIDTH:WIDTH+1] : work_q[2*WIDTH:WIDTH+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      dvs_q     <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i && !annul_i) begin
            cnt_q <= '0;
            if (opdata2_i == '0) begin
              state_q <= BYZERO;
            end else begin
              dvs_q     <= absB;
              work_q    <= {{WIDTH{1'b0}}, absA, 1'b0};
              negQuot_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              negRem_q  <= signed_div_i && opdata1_i[WIDTH-1];
              state_q   <= ON;
            end
          end
        end
        // Divide-by-zero spends two edges here so its result lands two edges after acceptance
        BYZERO: begin
          if (annul_i) begin
            state_q <= FREE;
          end else if (cnt_q == '0) begin
            cnt_q <= CW'(1);
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        ON: begin
          if (annul_i) begin
            state_q <= FREE;
          end else if (cnt_q != CW'(WIDTH)) begin
            if (diff[WIDTH+1]) begin
              work_q <= {work_q[2*WIDTH-1:0], 1'b0};
            end else begin
              work_q <= {diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};
            end
            cnt_q <= cnt_q + CW'(1);
          end else begin
            result_q <= {remFix, quotFix};
            ready_q  <= 1'b1;
            state_q  <= END;
          end
        end
        END: begin
          if (!start_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= FREE;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit: results, latency, hold/release, annul and reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signedDiv;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  logic [63:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signedDiv),
    .opdata1_i    (opA),
    .opdata2_i    (opB),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Drive a request, queue its expected result, then scramble the operands after acceptance
  task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp);
    @(negedge clk);
    signedDiv = s;
    opA       = a;
    opB       = b;
    annul     = 1'b0;
    start     = 1'b1;
    sb.push_back(exp);
    @(negedge clk);
    opA = $urandom;
    opB = $urandom;
  endtask

  // Wait for ready with a bound, check latency and result, hold, then release
  task automatic checkOutput(input string tag, input int expLat);
    int          k;
    logic [63:0] exp;
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkValue({tag, " latency"}, 64'(k), 64'(expLat));
    if (sb.size() == 0) begin
      checkValue({tag, " scoreboard"}, 64'(sb.size()), 64'd1);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    checkValue({tag, " result"}, result, exp);
    @(negedge clk);
    checkValue({tag, " held ready"}, 64'(ready), 64'd1);
    checkValue({tag, " held result"}, result, exp);
    start = 1'b0;
    @(negedge clk);
    checkValue({tag, " release ready"}, 64'(ready), 64'd0);
    checkValue({tag, " release result"}, result, 64'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    rst       = 1'b1;
    signedDiv = 1'b0;
    opA       = '0;
    opB       = '0;
    start     = 1'b0;
    annul     = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("reset ready", 64'(ready), 64'd0);
    checkValue("reset result", result, 64'd0);
    rst = 1'b0;

    applyStimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    checkOutput("udiv 100/7", 33);

    applyStimulus(1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
    checkOutput("sdiv -7/2", 33);

    applyStimulus(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
    checkOutput("sdiv 7/-2", 33);

    applyStimulus(1'b0, 32'd5, 32'd0, 64'h0);
    checkOutput("div by zero", 2);

    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
    checkOutput("udiv max/1", 33);

    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
    checkOutput("sdiv overflow", 33);

    // Annul in the middle of the iterations
    @(negedge clk);
    signedDiv = 1'b0;
    opA       = 32'd100;
    opB       = 32'd7;
    start     = 1'b1;
    repeat (11) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    checkValue("annul no ready", 64'(seen), 64'd0);

    // Start and annul together in FREE must not be accepted
    start = 1'b1;
    annul = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready !== 1'b0) seen = 1'b1;
    end
    start = 1'b0;
    annul = 1'b0;
    checkValue("start+annul no ready", 64'(seen), 64'd0);

    applyStimulus(1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
    checkOutput("after annul 9/3", 33);

    // Reset mid-operation
    @(negedge clk);
    opA   = 32'd100;
    opB   = 32'd7;
    start = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkValue("midop reset ready", 64'(ready), 64'd0);
    checkValue("midop reset result", result, 64'd0);
    rst   = 1'b0;
    start = 1'b0;
    applyStimulus(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
    checkOutput("after reset 100/7", 33);

    for (int i = 0; i < 4; i++) begin
      rs = i[0];
      ra = $urandom;
      rb = $urandom >> (i * 8);
      if (rb == 32'd0) rb = 32'd1;
      if (rs && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd3;
      applyStimulus(rs, ra, rb, model(rs, ra, rb));
      checkOutput($sformatf("random %0d", i), 33);
    end

    checkValue("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
